// File: rtl/al422_pkg.sv
// ---------------------------------------------------------------------------
// al422_pkg : shared AL422 types and constants for the write and read sides.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package al422_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRST  = 3'd1,
    GUARD = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } al422_wr_state_t;

  localparam int AL422_DEPTH = 393216;

  // Control-byte layout, decoded by the read side.
  localparam int         CTRL_OE_INV_BIT = 7;
  localparam logic [7:0] CTRL_ROW_MASK   = 8'h1F;

endpackage

`default_nettype wire

// File: rtl/al422_frame_writer_if.sv
// ---------------------------------------------------------------------------
// al422_frame_writer_if : byte stream, AL422 write pins and frame status.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface al422_frame_writer_if #(
  parameter int COUNT_W = 19
);
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [7:0]         al422_data_out;
  logic               al422_we_out;
  logic               al422_wrst_out;
  logic               frame_done;
  logic [COUNT_W-1:0] frame_bytes;
  logic               overflow;
  logic [7:0]         frame_checksum;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, al422_data_out, al422_we_out, al422_wrst_out,
    input  frame_done, frame_bytes, overflow, frame_checksum
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, al422_data_out, al422_we_out, al422_wrst_out,
    output frame_done, frame_bytes, overflow, frame_checksum
  );
endinterface

`default_nettype wire

// File: rtl/al422_wrst_pulse.sv
// ---------------------------------------------------------------------------
// al422_wrst_pulse : fixed-width active-low pulse, WIDTH clocks after start.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module al422_wrst_pulse #(
  parameter int WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic wrst_n_o,
  output logic done_o
);
  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LOAD = CW'(WIDTH - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = C_LOAD;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wrst_n_o = ~active_q;
  // High during the last low clock so the caller leaves WRST on the release edge.
  assign done_o   = active_q && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/al422_frame_writer.sv
// ---------------------------------------------------------------------------
// al422_frame_writer : AL422 write-side controller (frame reset, strobes,
// byte count, overflow). Optional checksum: AL422_WR_CHECKSUM_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module al422_frame_writer
  import al422_pkg::*;
#(
  parameter int WRST_CYCLES = 4,
  parameter int MAX_BYTES   = AL422_DEPTH,
  parameter int COUNT_W     = 19
) (
  input  logic                in_clk,
  input  logic                in_rst,
  al422_frame_writer_if.slave bus
);
  localparam logic [COUNT_W-1:0] C_MAX_CNT = COUNT_W'(MAX_BYTES);

  al422_wr_state_t    state_q, state_d;
  logic [7:0]         skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               we_n_q, we_n_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] fbytes_q, fbytes_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               w_arm;
  logic               w_wr_en;
  logic [7:0]         w_wr_byte;
  logic               w_ready;
  logic               w_wrst_n;
  logic               w_wrst_done;

  al422_wrst_pulse #(
    .WIDTH (WRST_CYCLES)
  ) u_wrst_pulse (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .start_i  (w_arm),
    .wrst_n_o (w_wrst_n),
    .done_o   (w_wrst_done)
  );

  always_comb begin
    state_d     = state_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    count_d     = count_q;
    ovf_d       = ovf_q;
    fbytes_d    = fbytes_q;
    done_d      = 1'b0;
    w_arm       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_byte   = 8'h00;
    w_ready     = 1'b0;

    unique case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.s_valid) begin
          skid_data_d = bus.s_data;
          skid_last_d = bus.s_last;
          w_arm       = 1'b1;
          count_d     = '0;
          ovf_d       = 1'b0;
          state_d     = WRST;
        end
      end
      WRST: begin
        if (w_wrst_done) state_d = GUARD;
      end
      GUARD: begin
        w_wr_en   = 1'b1;
        w_wr_byte = skid_data_q;
        state_d   = skid_last_q ? DONE : WRITE;
      end
      WRITE: begin
        w_ready = 1'b1;
        if (bus.s_valid) begin
          // A full FIFO still drains the stream; the byte is dropped.
          if (count_q == C_MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_byte = bus.s_data;
          end
          if (bus.s_last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_wr_en) begin
      wdata_d = w_wr_byte;
      we_n_d  = 1'b0;
      count_d = count_q + COUNT_W'(1);
    end

    if (state_d == DONE) begin
      done_d   = 1'b1;
      fbytes_d = count_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= IDLE;
      skid_data_q <= 8'h00;
      skid_last_q <= 1'b0;
      wdata_q     <= 8'h00;
      we_n_q      <= 1'b1;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      fbytes_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      fbytes_q    <= fbytes_d;
      done_q      <= done_d;
    end
  end

`ifdef AL422_WR_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] csum_q, csum_d;

  always_comb begin
    sum_d  = sum_q;
    csum_d = csum_q;
    if (w_arm) begin
      sum_d = 8'h00;
    end else if (w_wr_en) begin
      sum_d = sum_q + w_wr_byte;
    end
    if (state_d == DONE) csum_d = sum_d;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sum_q  <= 8'h00;
      csum_q <= 8'h00;
    end else begin
      sum_q  <= sum_d;
      csum_q <= csum_d;
    end
  end

  assign bus.frame_checksum = csum_q;
`else
  assign bus.frame_checksum = 8'h00;
`endif

  assign bus.s_ready        = w_ready;
  assign bus.al422_data_out = wdata_q;
  assign bus.al422_we_out   = we_n_q;
  assign bus.al422_wrst_out = w_wrst_n;
  assign bus.frame_done     = done_q;
  assign bus.frame_bytes    = fbytes_q;
  assign bus.overflow       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_al422_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_al422_frame_writer : directed self-checking bench for al422_frame_writer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_al422_frame_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] t_data;
  logic       t_valid;
  logic       t_last;
  logic       sel;   // 0: default instance, 1: small-capacity instance

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  al422_frame_writer_if #(.COUNT_W(19)) b0 ();
  al422_frame_writer_if #(.COUNT_W(5))  b1 ();

  assign b0.s_data  = t_data;
  assign b0.s_last  = t_last;
  assign b0.s_valid = t_valid & ~sel;
  assign b1.s_data  = t_data;
  assign b1.s_last  = t_last;
  assign b1.s_valid = t_valid & sel;

  al422_frame_writer #(.WRST_CYCLES(4), .MAX_BYTES(393216), .COUNT_W(19)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (b0)
  );

  al422_frame_writer #(.WRST_CYCLES(4), .MAX_BYTES(16), .COUNT_W(5)) dut_small (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (b1)
  );

  logic        m_ready, m_we, m_wrst, m_done, m_ovf;
  logic [7:0]  m_data, m_csum;
  logic [18:0] m_fbytes;

  assign m_ready  = sel ? b1.s_ready        : b0.s_ready;
  assign m_we     = sel ? b1.al422_we_out   : b0.al422_we_out;
  assign m_wrst   = sel ? b1.al422_wrst_out : b0.al422_wrst_out;
  assign m_done   = sel ? b1.frame_done     : b0.frame_done;
  assign m_ovf    = sel ? b1.overflow       : b0.overflow;
  assign m_data   = sel ? b1.al422_data_out : b0.al422_data_out;
  assign m_csum   = sel ? b1.frame_checksum : b0.frame_checksum;
  assign m_fbytes = sel ? 19'(b1.frame_bytes) : b0.frame_bytes;

  // Observed /WE strobes, /WRST low clocks and frame_done pulses.
  logic [7:0]  wq[$];
  logic [18:0] fbq[$];
  int we_n, we_first, we_last, wrst_n, wrst_first, rdy_in_wrst, done_n;

  always @(negedge clk) begin
    if (m_we === 1'b0) begin
      wq.push_back(m_data);
      if (we_n == 0) we_first = cyc;
      we_last = cyc;
      we_n++;
    end
    if (m_wrst === 1'b0) begin
      if (wrst_n == 0) wrst_first = cyc;
      wrst_n++;
      if (m_ready !== 1'b0) rdy_in_wrst++;
    end
    if (m_done === 1'b1) begin
      done_n++;
      fbq.push_back(m_fbytes);
    end
  end

  task automatic clear_mon();
    wq.delete();
    fbq.delete();
    we_n = 0; we_first = 0; we_last = 0;
    wrst_n = 0; wrst_first = 0; rdy_in_wrst = 0; done_n = 0;
  endtask

  task automatic drive(input logic [7:0] d[$], input bit gap, input bit mark_last,
                       input bit hold, output int stalls);
    stalls = 0;
    foreach (d[i]) begin
      t_data  = d[i];
      t_last  = mark_last && (i == d.size() - 1);
      t_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (m_ready === 1'b1) break;
        stalls++;
        if (stalls > 200) begin
          stalls  = 9999;
          t_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      if (gap) begin
        t_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (!hold) t_valid = 1'b0;
  endtask

  function automatic logic [7:0] exp_csum(input logic [7:0] d[$], input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + d[i];
`ifdef AL422_WR_CHECKSUM_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b0.s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", b0.s_ready); end
    total++; if (b0.al422_we_out !== 1'b1) begin bad++; $display("FAIL reset_we got=%b want=1", b0.al422_we_out); end
    total++; if (b0.al422_wrst_out !== 1'b1) begin bad++; $display("FAIL reset_wrst got=%b want=1", b0.al422_wrst_out); end
    total++; if (b0.al422_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", b0.al422_data_out); end
    total++; if (b0.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", b0.frame_done); end
    total++; if (b0.frame_bytes !== 19'd0) begin bad++; $display("FAIL reset_fbytes got=%0d want=0", b0.frame_bytes); end
    total++; if (b0.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", b0.overflow); end
    total++; if (b0.frame_checksum !== 8'h00) begin bad++; $display("FAIL reset_csum got=%h want=00", b0.frame_checksum); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    int st;
    d = '{8'h2F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h74};
    sel = 1'b0;
    clear_mon();
    drive(d, 1'b0, 1'b1, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    total++; if (st !== 5) begin bad++; $display("FAIL basic_stalls got=%0d want=5", st); end
    total++; if (wrst_n !== 4) begin bad++; $display("FAIL basic_wrst_len got=%0d want=4", wrst_n); end
    total++; if (rdy_in_wrst !== 0) begin bad++; $display("FAIL basic_ready_in_wrst got=%0d want=0", rdy_in_wrst); end
    total++; if (we_n !== 12) begin bad++; $display("FAIL basic_we_count got=%0d want=12", we_n); end
    total++; if (we_last - we_first + 1 !== 12) begin bad++; $display("FAIL basic_we_contig span=%0d want=12", we_last - we_first + 1); end
    total++; if (we_first - wrst_first !== 5) begin bad++; $display("FAIL basic_we_latency got=%0d want=5", we_first - wrst_first); end
    for (int i = 0; i < 12; i++) begin
      total++; if (wq[i] !== d[i]) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, wq[i], d[i]); end
    end
    total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_n); end
    total++; if (b0.frame_bytes !== 19'd12) begin bad++; $display("FAIL basic_fbytes got=%0d want=12", b0.frame_bytes); end
    total++; if (b0.overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", b0.overflow); end
    total++; if (b0.frame_checksum !== exp_csum(d, 12)) begin bad++; $display("FAIL basic_csum got=%h want=%h", b0.frame_checksum, exp_csum(d, 12)); end
  endtask

  task automatic test_toggle();
    logic [7:0] d[$];
    int st;
    for (int i = 0; i < 120; i++) d.push_back((i % 12 == 11) ? 8'h74 : 8'h44);
    sel = 1'b0;
    clear_mon();
    drive(d, 1'b1, 1'b1, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    total++; if (st !== 4) begin bad++; $display("FAIL toggle_stalls got=%0d want=4", st); end
    total++; if (we_n !== 120) begin bad++; $display("FAIL toggle_we_count got=%0d want=120", we_n); end
    total++; if (we_last - we_first + 1 !== 238) begin bad++; $display("FAIL toggle_we_span got=%0d want=238", we_last - we_first + 1); end
    for (int i = 0; i < 120; i++) begin
      total++; if (wq[i] !== d[i]) begin bad++; $display("FAIL toggle_data[%0d] got=%h want=%h", i, wq[i], d[i]); end
    end
    total++; if (done_n !== 1) begin bad++; $display("FAIL toggle_done_pulses got=%0d want=1", done_n); end
    total++; if (b0.frame_bytes !== 19'd120) begin bad++; $display("FAIL toggle_fbytes got=%0d want=120", b0.frame_bytes); end
  endtask

  task automatic test_overflow();
    logic [7:0] d[$];
    logic [7:0] n[$];
    int st;
    for (int i = 0; i < 20; i++) d.push_back(8'h10 + 8'(i));
    sel = 1'b1;
    clear_mon();
    drive(d, 1'b0, 1'b1, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    total++; if (st !== 5) begin bad++; $display("FAIL ovf_stalls got=%0d want=5", st); end
    total++; if (we_n !== 16) begin bad++; $display("FAIL ovf_we_count got=%0d want=16", we_n); end
    for (int i = 0; i < 16; i++) begin
      total++; if (wq[i] !== d[i]) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=%h", i, wq[i], d[i]); end
    end
    total++; if (b1.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", b1.overflow); end
    total++; if (b1.frame_bytes !== 5'd16) begin bad++; $display("FAIL ovf_fbytes got=%0d want=16", b1.frame_bytes); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL ovf_done_pulses got=%0d want=1", done_n); end
    total++; if (b1.frame_checksum !== exp_csum(d, 16)) begin bad++; $display("FAIL ovf_csum got=%h want=%h", b1.frame_checksum, exp_csum(d, 16)); end
    n = '{8'h55};
    clear_mon();
    drive(n, 1'b0, 1'b1, 1'b0, st);
    total++; if (b1.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_at_start got=%b want=0", b1.overflow); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (b1.frame_bytes !== 5'd1) begin bad++; $display("FAIL ovf_next_fbytes got=%0d want=1", b1.frame_bytes); end
    total++; if (b1.overflow !== 1'b0) begin bad++; $display("FAIL ovf_next_flag got=%b want=0", b1.overflow); end
    sel = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] d[$];
    int st;
    d = '{8'hA5};
    sel = 1'b0;
    clear_mon();
    drive(d, 1'b0, 1'b1, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    total++; if (st !== 0) begin bad++; $display("FAIL single_stalls got=%0d want=0", st); end
    total++; if (wrst_n !== 4) begin bad++; $display("FAIL single_wrst_len got=%0d want=4", wrst_n); end
    total++; if (we_n !== 1) begin bad++; $display("FAIL single_we_count got=%0d want=1", we_n); end
    total++; if (wq[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", wq[0]); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL single_done_pulses got=%0d want=1", done_n); end
    total++; if (b0.frame_bytes !== 19'd1) begin bad++; $display("FAIL single_fbytes got=%0d want=1", b0.frame_bytes); end
    total++; if (b0.frame_checksum !== exp_csum(d, 1)) begin bad++; $display("FAIL single_csum got=%h want=%h", b0.frame_checksum, exp_csum(d, 1)); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    logic [7:0] n[$];
    int st;
    d = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    sel = 1'b0;
    clear_mon();
    drive(d, 1'b0, 1'b0, 1'b1, st);
    t_data = 8'h66;
    rst    = 1'b1;
    @(posedge clk); #1;
    total++; if (b0.al422_we_out !== 1'b1) begin bad++; $display("FAIL rmid_we got=%b want=1", b0.al422_we_out); end
    total++; if (b0.al422_wrst_out !== 1'b1) begin bad++; $display("FAIL rmid_wrst got=%b want=1", b0.al422_wrst_out); end
    total++; if (b0.s_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", b0.s_ready); end
    rst     = 1'b0;
    t_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (we_n !== 5) begin bad++; $display("FAIL rmid_we_count got=%0d want=5", we_n); end
    total++; if (done_n !== 0) begin bad++; $display("FAIL rmid_done_pulses got=%0d want=0", done_n); end
    n = '{8'h3C};
    clear_mon();
    drive(n, 1'b0, 1'b1, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    total++; if (wrst_n !== 4) begin bad++; $display("FAIL rmid_next_wrst_len got=%0d want=4", wrst_n); end
    total++; if (wq[0] !== 8'h3C) begin bad++; $display("FAIL rmid_next_data got=%h want=3c", wq[0]); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL rmid_next_done got=%0d want=1", done_n); end
    total++; if (b0.frame_bytes !== 19'd1) begin bad++; $display("FAIL rmid_next_fbytes got=%0d want=1", b0.frame_bytes); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] da[$];
    logic [7:0] db[$];
    logic [7:0] all[$];
    int sta, stb;
    da  = '{8'h01, 8'h02, 8'h03};
    db  = '{8'h11, 8'h12, 8'h13, 8'h14};
    all = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14};
    sel = 1'b0;
    clear_mon();
    drive(da, 1'b0, 1'b1, 1'b1, sta);
    drive(db, 1'b0, 1'b1, 1'b0, stb);
    repeat (20) @(posedge clk);
    #1;
    total++; if (sta !== 5) begin bad++; $display("FAIL b2b_stalls_a got=%0d want=5", sta); end
    total++; if (stb !== 6) begin bad++; $display("FAIL b2b_stalls_b got=%0d want=6", stb); end
    total++; if (wrst_n !== 8) begin bad++; $display("FAIL b2b_wrst_len got=%0d want=8", wrst_n); end
    total++; if (we_n !== 7) begin bad++; $display("FAIL b2b_we_count got=%0d want=7", we_n); end
    for (int i = 0; i < 7; i++) begin
      total++; if (wq[i] !== all[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, wq[i], all[i]); end
    end
    total++; if (done_n !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", done_n); end
    total++; if (fbq[0] !== 19'd3) begin bad++; $display("FAIL b2b_fbytes_a got=%0d want=3", fbq[0]); end
    total++; if (fbq[1] !== 19'd4) begin bad++; $display("FAIL b2b_fbytes_b got=%0d want=4", fbq[1]); end
    total++; if (b0.frame_checksum !== exp_csum(db, 4)) begin bad++; $display("FAIL b2b_csum got=%h want=%h", b0.frame_checksum, exp_csum(db, 4)); end
  endtask

  initial begin
    rst     = 1'b1;
    t_valid = 1'b0;
    t_data  = 8'h00;
    t_last  = 1'b0;
    sel     = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_toggle();
    test_overflow();
    test_single();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
